// File: rtl/alu_issue_dec.sv
// alu_issue_dec: RV32I decode/issue stage feeding the ALU {a, b, op} interface.
// Decodes OP, OP-IMM and BRANCH instructions into a 5-bit ALU op and selects
// operand b (rs2 or immediate). Results go through a registered 2-entry
// skid buffer (MAIN/SKID) towards the execute stage.
//
// Optional feature: define ALU_ISSUE_UPPER_EN to decode LUI/AUIPC as ADD.
// Without it both opcodes are reported as illegal.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of all buffered entries
//   in_valid/in_ready instruction handshake (in_ready registered)
//   in_instr, in_rs1_val, in_rs2_val, in_pc   raw instruction + operands
//   out_valid/out_ready   decoded entry handshake
//   out_a, out_b, out_op  ALU operation
//   out_rd, out_we        destination register and write enable
//   out_is_branch, out_br_target, out_illegal   branch info / decode error
module alu_issue_dec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_op,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_is_branch,
  output logic [31:0] out_br_target,
  output logic        out_illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;

  localparam logic [OPW-1:0] OP_NONE = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,
                             OP_AND  = 5'd3,  OP_OR   = 5'd4,  OP_XOR  = 5'd5,
                             OP_SLL  = 5'd6,  OP_SRL  = 5'd7,  OP_SRA  = 5'd8,
                             OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_BEQ  = 5'd11,
                             OP_BNE  = 5'd12, OP_BLT  = 5'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OPW-1:0]  op;
    logic [4:0]      rd;
    logic            we;
    logic            is_branch;
    logic [XLEN-1:0] br_target;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  // Instruction fields and immediates
  logic [6:0]      opcode_c;
  logic [2:0]      funct3_c;
  logic [6:0]      funct7_c;
  logic [4:0]      rd_c;
  logic [XLEN-1:0] imm_i_c, imm_b_c, shamt_c;
  logic            unused_ok_c;

  assign opcode_c    = in_instr[6:0];
  assign funct3_c    = in_instr[14:12];
  assign funct7_c    = in_instr[31:25];
  assign rd_c        = in_instr[11:7];
  assign imm_i_c     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_b_c     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
  assign shamt_c     = {27'b0, in_instr[24:20]};
  // rs1 index is resolved by the register file, not here
  assign unused_ok_c = ^in_instr[19:15];

  // funct3 -> ALU op shared by OP and OP-IMM
  logic [OPW-1:0] f3_op_c;
  always_comb begin
    f3_op_c = OP_NONE;
    case (funct3_c)
      3'b000:  f3_op_c = OP_ADD;
      3'b001:  f3_op_c = OP_SLL;
      3'b010:  f3_op_c = OP_SLT;
      3'b011:  f3_op_c = OP_SLTU;
      3'b100:  f3_op_c = OP_XOR;
      3'b101:  f3_op_c = OP_SRL;
      3'b110:  f3_op_c = OP_OR;
      default: f3_op_c = OP_AND;
    endcase
  end

  // Instruction decode into a buffer entry
  logic [OPW-1:0]  dec_op_c;
  logic [XLEN-1:0] dec_a_c, dec_b_c;
  logic            dec_wr_cls_c, dec_br_c, dec_legal_c;
  entry_t          dec_c;

  always_comb begin
    dec_op_c     = OP_NONE;
    dec_a_c      = in_rs1_val;
    dec_b_c      = in_rs2_val;
    dec_wr_cls_c = 1'b0;
    dec_br_c     = 1'b0;
    case (opcode_c)
      OPC_OP: begin
        if (funct7_c == F7_BASE)                             dec_op_c = f3_op_c;
        else if (funct7_c == F7_ALT && funct3_c == 3'b000)   dec_op_c = OP_SUB;
        else if (funct7_c == F7_ALT && funct3_c == 3'b101)   dec_op_c = OP_SRA;
        dec_wr_cls_c = 1'b1;
      end
      OPC_OP_IMM: begin
        if (funct3_c == 3'b001) begin
          if (funct7_c == F7_BASE) dec_op_c = OP_SLL;
          dec_b_c = shamt_c;
        end else if (funct3_c == 3'b101) begin
          if (funct7_c == F7_BASE)     dec_op_c = OP_SRL;
          else if (funct7_c == F7_ALT) dec_op_c = OP_SRA;
          dec_b_c = shamt_c;
        end else begin
          dec_op_c = f3_op_c;
          dec_b_c  = imm_i_c;
        end
        dec_wr_cls_c = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3_c)
          3'b000:  dec_op_c = OP_BEQ;
          3'b001:  dec_op_c = OP_BNE;
          3'b100:  dec_op_c = OP_BLT;
          default: dec_op_c = OP_NONE;
        endcase
        dec_br_c = 1'b1;
      end
`ifdef ALU_ISSUE_UPPER_EN
      OPC_LUI: begin
        dec_op_c     = OP_ADD;
        dec_a_c      = '0;
        dec_b_c      = {in_instr[31:12], 12'b0};
        dec_wr_cls_c = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op_c     = OP_ADD;
        dec_a_c      = in_pc;
        dec_b_c      = {in_instr[31:12], 12'b0};
        dec_wr_cls_c = 1'b1;
      end
`endif
      default: dec_op_c = OP_NONE;
    endcase

    // Every legal encoding yields a nonzero op; illegal ones fall back to raw operands
    dec_legal_c = (dec_op_c != OP_NONE);
    if (!dec_legal_c) begin
      dec_a_c      = in_rs1_val;
      dec_b_c      = in_rs2_val;
      dec_wr_cls_c = 1'b0;
      dec_br_c     = 1'b0;
    end

    dec_c.a         = dec_a_c;
    dec_c.b         = dec_b_c;
    dec_c.op        = dec_op_c;
    dec_c.rd        = rd_c;
    dec_c.we        = dec_wr_cls_c & (rd_c != 5'd0);
    dec_c.is_branch = dec_br_c;
    dec_c.br_target = dec_legal_c ? XLEN'(in_pc + imm_b_c) : '0;
    dec_c.illegal   = !dec_legal_c;
  end

  // Skid buffer control
  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic   acc_c, pop_c;

  assign acc_c = in_valid & in_ready_q;
  assign pop_c = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (acc_c) begin
          main_d  = dec_c;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (acc_c && !pop_c) begin
          skid_d  = dec_c;
          state_d = S_TWO;
        end else if (acc_c && pop_c) begin
          main_d  = dec_c;
        end else if (pop_c) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop_c) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_a         = main_q.a;
  assign out_b         = main_q.b;
  assign out_op        = main_q.op;
  assign out_rd        = main_q.rd;
  assign out_we        = main_q.we;
  assign out_is_branch = main_q.is_branch;
  assign out_br_target = main_q.br_target;
  assign out_illegal   = main_q.illegal;

endmodule
